// File: rtl/elastic_pr_pkg.sv
// Core package: pipeline-register state encoding plus the stage payload structs
// and their NOP literals used as BUBBLE values by elastic_pr instances.
package elastic_pr_pkg;

  // Encoded so that the enum value equals the number of held entries.
  typedef enum logic [1:0] {
    PR_EMPTY = 2'd0,
    PR_ONE   = 2'd1,
    PR_TWO   = 2'd2
  } pr_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        wr_en;
  } decode_pl_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        wr_en;
  } execute_pl_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        wr_en;
  } memory_pl_t;

  typedef struct packed {
    logic [31:0] wr_data;
    logic [4:0]  rd;
    logic        wr_en;
  } writeback_pl_t;

  localparam fetch_pl_t FETCH_NOP = '{pc: 32'h0, instr: NOP_INSTR};

  localparam decode_pl_t DECODE_NOP = '{
    pc: 32'h0, rs1_val: 32'h0, rs2_val: 32'h0, imm: 32'h0,
    rd: 5'd0, alu_op: 4'd0, wr_en: 1'b0
  };

  localparam execute_pl_t EXECUTE_NOP = '{
    alu_res: 32'h0, store_data: 32'h0, rd: 5'd0,
    mem_rd: 1'b0, mem_wr: 1'b0, wr_en: 1'b0
  };

  localparam memory_pl_t MEMORY_NOP = '{result: 32'h0, rd: 5'd0, wr_en: 1'b0};

  localparam writeback_pl_t WRITEBACK_NOP = '{wr_data: 32'h0, rd: 5'd0, wr_en: 1'b0};

  function automatic logic [1:0] pr_occupancy(input pr_state_t s);
    case (s)
      PR_ONE:  pr_occupancy = 2'd1;
      PR_TWO:  pr_occupancy = 2'd2;
      default: pr_occupancy = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/elastic_pr.sv
// Handshaked pipeline register with optional 2-entry skid buffer and flush.
// Handshake: a beat moves when valid & ready are both 1 on a rising clk edge.
module elastic_pr
  import elastic_pr_pkg::*;
#(
  parameter int              WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter bit              SKID   = 1'b1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy
);

  pr_state_t        state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             acc;
  logic             pop;

  assign out_valid = (state_q != PR_EMPTY);
  assign out_data  = head_q;
  assign occupancy = pr_occupancy(state_q);
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= PR_EMPTY;
      head_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
    end
  end

  generate
    if (SKID) begin : g_skid
      logic [WIDTH-1:0] skid_q, skid_d;
      logic             in_ready_q, in_ready_d;

      // in_ready comes straight from a flop: no path from out_ready.
      assign in_ready = in_ready_q;

      always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
          state_d = PR_EMPTY;
          head_d  = BUBBLE;
          skid_d  = BUBBLE;
        end else begin
          case (state_q)
            PR_EMPTY: begin
              if (acc) begin
                state_d = PR_ONE;
                head_d  = in_data;
              end
            end
            PR_ONE: begin
              if (acc && pop) begin
                head_d = in_data;
              end else if (acc) begin
                state_d = PR_TWO;
                skid_d  = in_data;
              end else if (pop) begin
                state_d = PR_EMPTY;
                head_d  = BUBBLE;
              end
            end
            PR_TWO: begin
              // in_ready is 0 here, so only a pop can move the state.
              if (pop) begin
                state_d = PR_ONE;
                head_d  = skid_q;
                skid_d  = BUBBLE;
              end
            end
            default: begin
              state_d = PR_EMPTY;
              head_d  = BUBBLE;
              skid_d  = BUBBLE;
            end
          endcase
        end
        in_ready_d = (state_d != PR_TWO);
      end

      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          skid_q     <= BUBBLE;
          in_ready_q <= 1'b1;
        end else begin
          skid_q     <= skid_d;
          in_ready_q <= in_ready_d;
        end
      end
    end else begin : g_noskid
      assign in_ready = ~out_valid | out_ready;

      always_comb begin
        state_d = state_q;
        head_d  = head_q;
        if (flush) begin
          state_d = PR_EMPTY;
          head_d  = BUBBLE;
        end else if (acc) begin
          state_d = PR_ONE;
          head_d  = in_data;
        end else if (pop) begin
          state_d = PR_EMPTY;
          head_d  = BUBBLE;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_elastic_pr.sv
// Bench for elastic_pr: one SKID=1 and one SKID=0 instance, directed scenarios
// followed by random traffic, scored against a FIFO-queue reference model.
module tb_elastic_pr;

  localparam int W = 8;
  localparam logic [W-1:0] BUB_S = 8'hE5;
  localparam logic [W-1:0] BUB_N = 8'h3C;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic         s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_flush;
  logic [W-1:0] s_in_data, s_out_data;
  logic [1:0]   s_occ;
  logic         n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_flush;
  logic [W-1:0] n_in_data, n_out_data;
  logic [1:0]   n_occ;

  elastic_pr #(.WIDTH(W), .BUBBLE(BUB_S), .SKID(1'b1)) u_skid (
    .clk(clk), .nrst(nrst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .flush(s_flush), .occupancy(s_occ)
  );

  elastic_pr #(.WIDTH(W), .BUBBLE(BUB_N), .SKID(1'b0)) u_noskid (
    .clk(clk), .nrst(nrst),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
    .flush(n_flush), .occupancy(n_occ)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q_s[$];
  logic [W-1:0] exp_q_n[$];
  logic [W-1:0] got_n[$];
  logic         held_s = 1'b0;
  logic         held_n = 1'b0;
  int           n_tests = 0;
  int           n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_s(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    s_in_valid = iv; s_in_data = d; s_out_ready = ordy; s_flush = fl;
  endtask

  task automatic set_n(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    n_in_valid = iv; n_in_data = d; n_out_ready = ordy; n_flush = fl;
  endtask

  task automatic check_outs();
    check("s_out_valid", 32'(s_out_valid), 32'(exp_q_s.size() != 0));
    check("s_occupancy", 32'(s_occ), 32'(exp_q_s.size()));
    check("s_out_data", 32'(s_out_data), 32'((exp_q_s.size() != 0) ? exp_q_s[0] : BUB_S));
    check("n_out_valid", 32'(n_out_valid), 32'(exp_q_n.size() != 0));
    check("n_occupancy", 32'(n_occ), 32'(exp_q_n.size()));
    check("n_out_data", 32'(n_out_data), 32'((exp_q_n.size() != 0) ? exp_q_n[0] : BUB_N));
  endtask

  // One clock: called at a falling edge with inputs already driven.
  task automatic cycle();
    logic rdy_s, rdy_n, acc_s, acc_n, pop_s, pop_n;
    #1;
    rdy_s = (exp_q_s.size() < 2);
    rdy_n = (exp_q_n.size() == 0) || n_out_ready;
    check("s_in_ready", 32'(s_in_ready), 32'(rdy_s));
    check("n_in_ready", 32'(n_in_ready), 32'(rdy_n));
    acc_s = s_in_valid && rdy_s;
    acc_n = n_in_valid && rdy_n;
    pop_s = (exp_q_s.size() != 0) && s_out_ready;
    pop_n = (exp_q_n.size() != 0) && n_out_ready;
    held_s = s_in_valid && !rdy_s;
    held_n = n_in_valid && !rdy_n;
    if (pop_n) got_n.push_back(n_out_data);
    @(posedge clk);
    if (pop_s) void'(exp_q_s.pop_front());
    if (s_flush) exp_q_s.delete();
    else if (acc_s) exp_q_s.push_back(s_in_data);
    if (pop_n) void'(exp_q_n.pop_front());
    if (n_flush) exp_q_n.delete();
    else if (acc_n) exp_q_n.push_back(n_in_data);
    @(negedge clk);
    check_outs();
  endtask

  task automatic drive_rand();
    if (!held_s) begin
      s_in_valid = ($urandom_range(0, 3) != 0);
      s_in_data  = W'($urandom);
    end
    s_out_ready = ($urandom_range(0, 2) != 0);
    s_flush     = ($urandom_range(0, 15) == 0);
    if (!held_n) begin
      n_in_valid = ($urandom_range(0, 3) != 0);
      n_in_data  = W'($urandom);
    end
    n_out_ready = ($urandom_range(0, 2) != 0);
    n_flush     = ($urandom_range(0, 15) == 0);
  endtask

  task automatic mid_reset();
    nrst = 1'b0;
    #1;
    check("rst_s_valid", 32'(s_out_valid), 32'd0);
    check("rst_s_occ", 32'(s_occ), 32'd0);
    check("rst_s_data", 32'(s_out_data), 32'(BUB_S));
    check("rst_s_ready", 32'(s_in_ready), 32'd1);
    check("rst_n_valid", 32'(n_out_valid), 32'd0);
    check("rst_n_data", 32'(n_out_data), 32'(BUB_N));
    exp_q_s.delete();
    exp_q_n.delete();
    held_s = 1'b0;
    held_n = 1'b0;
    set_s(1'b0, '0, 1'b0, 1'b0);
    set_n(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] vals_n[3];
  int k;

  initial begin
    vals_n[0] = 8'd7; vals_n[1] = 8'd8; vals_n[2] = 8'd9;
    set_s(1'b0, '0, 1'b0, 1'b0);
    set_n(1'b0, '0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_outs();
    check("reset_s_in_ready", 32'(s_in_ready), 32'd1);
    check("reset_n_in_ready", 32'(n_in_ready), 32'd1);
    nrst = 1'b1;
    repeat (5) cycle();

    // streaming, full throughput
    for (int i = 1; i <= 4; i++) begin
      set_s(1'b1, W'(i), 1'b1, 1'b0);
      cycle();
      check("s_stream", 32'(s_out_data), i);
    end
    set_s(1'b0, '0, 1'b1, 1'b0);
    cycle();
    check("s_stream_drain", 32'(s_out_valid), 32'd0);

    // backpressure into TWO, then release
    set_s(1'b1, 8'h0A, 1'b0, 1'b0); cycle();
    set_s(1'b1, 8'h0B, 1'b0, 1'b0); cycle();
    check("bp_occ2", 32'(s_occ), 32'd2);
    check("bp_ready0", 32'(s_in_ready), 32'd0);
    check("bp_head", 32'(s_out_data), 32'h0A);
    set_s(1'b1, 8'h0C, 1'b0, 1'b0); cycle();
    check("bp_hold_occ", 32'(s_occ), 32'd2);
    set_s(1'b1, 8'h0C, 1'b1, 1'b0); cycle();
    check("bp_order_b", 32'(s_out_data), 32'h0B);
    cycle();
    check("bp_order_c", 32'(s_out_data), 32'h0C);
    set_s(1'b0, '0, 1'b1, 1'b0); cycle();
    check("bp_drained", 32'(s_out_valid), 32'd0);

    // flush while in TWO with a beat offered
    set_s(1'b1, 8'h01, 1'b0, 1'b0); cycle();
    set_s(1'b1, 8'h02, 1'b0, 1'b0); cycle();
    set_s(1'b1, 8'h03, 1'b0, 1'b1); cycle();
    check("flush_occ", 32'(s_occ), 32'd0);
    check("flush_valid", 32'(s_out_valid), 32'd0);
    check("flush_data", 32'(s_out_data), 32'(BUB_S));
    set_s(1'b0, '0, 1'b1, 1'b0);
    repeat (3) begin
      cycle();
      check("flush_no_stale", 32'(s_out_valid), 32'd0);
    end

    // flush in ONE discards the beat accepted that same cycle
    set_s(1'b1, 8'h44, 1'b0, 1'b0); cycle();
    set_s(1'b1, 8'h55, 1'b0, 1'b1); cycle();
    check("flush1_occ", 32'(s_occ), 32'd0);
    set_s(1'b0, '0, 1'b1, 1'b0); cycle();
    check("flush1_no_stale", 32'(s_out_valid), 32'd0);

    // simultaneous accept and pop in ONE
    set_s(1'b1, 8'h05, 1'b0, 1'b0); cycle();
    set_s(1'b1, 8'h06, 1'b1, 1'b0); cycle();
    check("accpop_head", 32'(s_out_data), 32'h06);
    check("accpop_occ", 32'(s_occ), 32'd1);
    set_s(1'b0, '0, 1'b1, 1'b0); cycle();

    // SKID=0: in_ready follows out_ready combinationally
    got_n.delete();
    set_n(1'b1, vals_n[0], 1'b0, 1'b0); cycle();
    k = 1;
    for (int c = 0; c < 12; c++) begin
      n_in_valid = (k < 3);
      n_in_data  = (k < 3) ? vals_n[k] : '0;
      n_out_ready = 1'b0;
      #1;
      if (n_out_valid) check("n_ready_follow_lo", 32'(n_in_ready), 32'd0);
      n_out_ready = (c % 2 == 0);
      #1;
      if (n_out_valid) check("n_ready_follow", 32'(n_in_ready), 32'(n_out_ready));
      cycle();
      if (n_in_valid && !held_n) k++;
    end
    check("n_stream_count", 32'(got_n.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      check("n_stream_order", 32'((i < got_n.size()) ? got_n[i] : '1), 32'(vals_n[i]));
    set_n(1'b0, '0, 1'b1, 1'b0); cycle();

    // randomized traffic with one mid-stream reset
    for (int c = 0; c < 600; c++) begin
      if (c == 300) mid_reset();
      drive_rand();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/elastic_pr.md
Name: elastic_pr

Overview:
Parametrised, handshaked pipeline register for the core's stage boundaries. It generalises the fixed per-stage registers (stall/NOP inputs) to any payload width, with valid/ready flow control.
- An optional 2-entry skid buffer makes every output, including in_ready, registered.
- A flush input inserts a bubble.
- Stage payloads are packed structs from the core package, passed as a flat vector.

Parameters:
WIDTH, 32, payload width in bits (>=1)
BUBBLE, '0 (WIDTH bits), payload presented on out_data when no valid entry, e.g. packed NOP encoding
SKID, 1, 1 = 2-entry skid buffer (registered in_ready); 0 = single entry, in_ready combinational

Ports:
clk  input  1  clock, rising edge
nrst  input  1  reset, asynchronous, active-low
in_valid  input  1  upstream beat valid
in_ready  output  1  stage accepts beat this cycle
in_data  input  WIDTH  upstream payload
out_valid  output  1  downstream beat valid
out_ready  input  1  downstream accepts beat
out_data  output  WIDTH  head payload; BUBBLE when out_valid=0
flush  input  1  synchronous kill of all held and incoming beats
occupancy  output  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Handshake events:
  - acc = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Payload must be held stable by the upstream side while in_valid=1 & in_ready=0. The block never drops an accepted beat except on flush.
- Reset (nrst=0, async): state EMPTY, out_valid=0, in_ready=1, out_data=BUBBLE, occupancy=0, both entries cleared to BUBBLE.
- Storage: head register (drives out_data) and skid register (SKID=1 only).
- States:
  - EMPTY: out_valid=0.
  - ONE: head valid.
  - TWO: head and skid valid.
- SKID=1 rules:
  - in_ready=1 in EMPTY and ONE, 0 in TWO. It is a registered function of state, with no combinational path from out_ready.
  - EMPTY: acc -> ONE, head<=in_data.
  - ONE: acc & !pop -> TWO, skid<=in_data.
  - ONE: pop & !acc -> EMPTY.
  - ONE: acc & pop -> ONE, head<=in_data (full throughput).
  - TWO: pop -> ONE, head<=skid. acc is impossible in this state.
- SKID=0 rules:
  - in_ready = !out_valid | out_ready.
  - acc -> head<=in_data, state ONE.
  - pop & !acc -> EMPTY.
  - TWO is never reached.
- Latency: 1 cycle from acc to out_valid when the block is empty. Throughput is 1 beat/cycle when out_ready is held at 1.
- Ordering: strict FIFO; the head always holds the oldest beat.
- Flush (sync, highest priority over acc/pop):
  - Next state EMPTY; head and skid <= BUBBLE.
  - A beat accepted in the flush cycle is discarded. Upstream sees it as consumed.
  - A pop in the flush cycle still completes, since downstream sampled the head.
  - in_ready is unaffected during the flush cycle itself.
- occupancy: EMPTY=0, ONE=1, TWO=2; updates on the same edge as the state.
- Reset asserted mid-stream: immediate return to reset values; in-flight beats are lost.
- Never X on outputs after reset; unused skid logic is absent when SKID=0.

Decomposition:
- Shared core package: enum pr_state_t {PR_EMPTY, PR_ONE, PR_TWO} (2 bits).
- Stage payload packed structs (fetch/decode/execute/memory/writeback) also live in the core package. Instances use WIDTH=$bits(struct) and BUBBLE=the struct's NOP literal.
- No sub-module: the control state machine and the data registers live in one module, with the skid path under generate on SKID.

Test Plan:
- Reset, then idle: out_valid=0, in_ready=1, out_data=BUBBLE, occupancy=0, held for 5 cycles.
- Streaming, SKID=1, out_ready=1, in_data=1,2,3,4 back-to-back: out_data 1,2,3,4 on consecutive cycles, each 1 cycle after acceptance, in_ready stays 1.
- Backpressure, SKID=1: push 0xA, 0xB with out_ready=0. Then occupancy=2, in_ready=0, out_data=0xA and 0xC held on input is not accepted. Raise out_ready: 0xA, 0xB, 0xC emerge in order.
- Flush while in TWO with in_valid=1: next cycle occupancy=0, out_valid=0, out_data=BUBBLE, no stale beat ever emerges.
- Simultaneous acc+pop in ONE (head=5, in=6): head=6, occupancy stays 1, no bubble.
- SKID=0, out_valid=1, out_ready toggled 0/1: in_ready follows out_ready in the same cycle. Stream 7,8,9 is delivered in order with no loss.
